// File: rtl/idma_job_arbiter.sv
// idma_job_arbiter
//
// Lets NumInp job sources (1-D frontends, nd-midends) share one iDMA
// backend. A job is picked from the valid sources and forwarded to the
// backend request port. The index of each accepted job's source is pushed
// into an in-order tag FIFO. The backend completes jobs in issue order, so
// the FIFO head tells us which source each backend response belongs to.
//
// Parameters
//   NumInp          number of job sources (>= 2)
//   MaxOutstanding  tag FIFO depth = max accepted jobs awaiting a response
//                   (power of two, >= 2)
//   idma_req_t      backend job type
//   idma_rsp_t      backend response type
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_i / req_valid_i         jobs from the sources
//   req_ready_o                 per-source job accept
//   rsp_o / rsp_valid_o         responses to the sources
//   rsp_ready_i                 per-source response ready
//   req_o / req_valid_o         job to the backend
//   req_ready_i                 backend ready
//   rsp_i / rsp_valid_i         response from the backend
//   rsp_ready_o                 response ready to the backend
//   busy_o                      at least one job is outstanding
//
// Build option
//   IDMA_JOB_ARB_FIXED_PRIO_EN  when defined, the lowest valid index wins
//                               every arbitration and the round-robin
//                               pointer does not exist. Default: round-robin.
//
// Arbiter states
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no lock; a winner is chosen combinationally each cycle
//   ST_LOCKED | backend stalled a presented job; grant held on grant_q
module idma_job_arbiter #(
  parameter int unsigned NumInp         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  idma_req_t           req_i       [NumInp],
  input  logic [NumInp-1:0]   req_valid_i,
  output logic [NumInp-1:0]   req_ready_o,
  output idma_rsp_t           rsp_o       [NumInp],
  output logic [NumInp-1:0]   rsp_valid_o,
  input  logic [NumInp-1:0]   rsp_ready_i,
  output idma_req_t           req_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  idma_rsp_t           rsp_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  output logic                busy_o
);

  localparam int unsigned IdxW = $clog2(NumInp);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e state_q, state_d;
  idx_t   grant_q, grant_d;
  idx_t   fifo_q [MaxOutstanding];
  idx_t   fifo_d [MaxOutstanding];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;

  logic   full;
  logic   empty;
  idx_t   win;
  idx_t   gnt_idx;
  logic   gnt_vld;
  logic   push;
  logic   pop;
  idx_t   head;

  // Wrapping increment of a source index; NumInp need not be a power of two.
  function automatic idx_t next_idx(input idx_t i);
    return (32'(i) == NumInp - 1) ? '0 : i + idx_t'(1);
  endfunction

`ifdef IDMA_JOB_ARB_FIXED_PRIO_EN

  function automatic idx_t pick_fixed(input logic [NumInp-1:0] valid);
    idx_t w;
    logic found;
    w     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      if (!found && valid[idx_t'(k)]) begin
        w     = idx_t'(k);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = pick_fixed(req_valid_i);

`else

  idx_t rr_ptr_q, rr_ptr_d;

  // First valid index at or after ptr, wrapping around.
  function automatic idx_t pick_rr(input logic [NumInp-1:0] valid, input idx_t ptr);
    idx_t w;
    idx_t cand;
    logic found;
    w     = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand = idx_t'((32'(ptr) + k) % NumInp);
      if (!found && valid[cand]) begin
        w     = cand;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = pick_rr(req_valid_i, rr_ptr_q);

  // The pointer only advances on a handshake, past whoever was served.
  assign rr_ptr_d = push ? next_idx(gnt_idx) : rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`endif

  // Full is taken from the registered count: a pop in the same cycle does
  // not open a slot until the next cycle, which keeps req_valid_o free of
  // any path from rsp_valid_i / rsp_ready_i.
  assign full  = (count_q == cnt_t'(MaxOutstanding));
  assign empty = (count_q == '0);

  always_comb begin
    if (state_q == ST_LOCKED) begin
      gnt_idx = grant_q;
      gnt_vld = !full;
    end else begin
      gnt_idx = win;
      gnt_vld = (|req_valid_i) && !full;
    end
  end

  // Request path
  assign req_o       = req_i[gnt_idx];
  assign req_valid_o = gnt_vld;
  assign push        = gnt_vld && req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (gnt_vld) begin
      req_ready_o[gnt_idx] = req_ready_i;
    end
  end

  // Response path: only the source at the FIFO head sees the response.
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_ready_o = rsp_ready_i[head] && !empty;
  assign pop         = rsp_valid_i && rsp_ready_o;
  assign busy_o      = !empty;

  always_comb begin
    rsp_valid_o       = '0;
    rsp_valid_o[head] = rsp_valid_i && !empty;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumInp; i++) begin
      rsp_o[i] = rsp_i;
    end
  end

  // Lock: once a job is presented and stalled, keep presenting that source
  // until the backend takes it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (state_q == ST_IDLE) begin
      if (gnt_vld && !req_ready_i) begin
        state_d = ST_LOCKED;
        grant_d = win;
      end
    end else if (push) begin
      state_d = ST_IDLE;
    end
  end

  // Tag FIFO
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d         = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a backend protocol error; it is
  // ignored by the logic above but flagged here.
  rsp_on_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(rsp_valid_i && empty))
    else $error("idma_job_arbiter: backend response with no outstanding job");
`endif

endmodule

// File: tb/tb_idma_job_arbiter.sv
module tb_idma_job_arbiter;

  localparam int N = 2;
  localparam int M = 4;

  typedef logic [7:0] req_t;
  typedef logic [7:0] rsp_t;

`ifdef IDMA_JOB_ARB_FIXED_PRIO_EN
  localparam int EXP_CNT0 = 8;
  localparam int EXP_CNT1 = 0;
`else
  localparam int EXP_CNT0 = 4;
  localparam int EXP_CNT1 = 4;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni;
  req_t           req_i [N];
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  rsp_t           rsp_o [N];
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i;
  req_t           req_o;
  logic           req_valid_o;
  logic           req_ready_i;
  rsp_t           rsp_i;
  logic           rsp_valid_i;
  logic           rsp_ready_o;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  idma_job_arbiter #(
    .NumInp        (N),
    .MaxOutstanding(M),
    .idma_req_t    (req_t),
    .idma_rsp_t    (rsp_t)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rsp_o       (rsp_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .req_o       (req_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_i       (rsp_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .busy_o      (busy_o)
  );

  // Reference model: queue of owner indices, rotating priority pointer,
  // and the index currently held because the backend stalled it (-1: none).
  int m_q[$];
  int m_rr;
  int m_held;
  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt [N];
  int last_push;
  logic [N-1:0] pend;
  logic [N-1:0] exp_rr;

  function automatic void model_reset();
    m_q.delete();
    m_rr   = 0;
    m_held = -1;
  endfunction

  // Which source the arbiter should present this cycle, -1 for none.
  function automatic int pick();
    if (m_q.size() == M) return -1;
    if (m_held >= 0) return m_held;
`ifdef IDMA_JOB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (req_valid_i[k]) return k;
`else
    for (int k = 0; k < N; k++) if (req_valid_i[(m_rr + k) % N]) return (m_rr + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int g;
    int h;
    logic [N-1:0] ev;
    logic er;
    g = pick();
    chk("req_valid_o", req_valid_o, g >= 0);
    if (g >= 0) chk("req_o", req_o, req_i[g]);
    ev = '0;
    if (g >= 0 && req_ready_i) ev[g] = 1'b1;
    chk("req_ready_o", req_ready_o, ev);
    chk("busy_o", busy_o, m_q.size() > 0);
    ev = '0;
    er = 1'b0;
    if (m_q.size() > 0) begin
      h = m_q[0];
      if (rsp_valid_i) ev[h] = 1'b1;
      er = rsp_ready_i[h];
    end
    chk("rsp_valid_o", rsp_valid_o, ev);
    chk("rsp_ready_o", rsp_ready_o, er);
    for (int i = 0; i < N; i++) chk("rsp_o", rsp_o[i], rsp_i);
  endtask

  task automatic settle_check();
    #1;
    check_outputs();
  endtask

  task automatic clock_model();
    int g;
    int h;
    bit push;
    bit pop;
    g    = pick();
    push = (g >= 0) && (req_ready_i === 1'b1);
    pop  = 1'b0;
    if (m_q.size() > 0) begin
      h   = m_q[0];
      pop = rsp_valid_i && rsp_ready_i[h];
    end
    for (int i = 0; i < N; i++) if (rsp_valid_o[i] && rsp_ready_i[i]) rsp_cnt[i]++;
    last_push = push ? g : -1;
    @(posedge clk_i);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(g);
      m_held = -1;
      m_rr   = (g + 1) % N;
    end else if (g >= 0) begin
      m_held = g;
    end
    #1;
  endtask

  task automatic cycle();
    settle_check();
    clock_model();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_i[i] = req_t'($urandom);
    rsp_i = rsp_t'($urandom);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_ready_i = '0;
    rsp_i       = '0;
    for (int i = 0; i < N; i++) begin
      req_i[i]   = '0;
      rsp_cnt[i] = 0;
    end
    model_reset();

    // Reset values
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, '0);
    chk("rst_rsp_ready", rsp_ready_o, 1'b0);
    chk("rst_req_ready", req_ready_o, '0);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fairness: both sources always valid, backend always ready,
    // responses returned as soon as a job is outstanding.
    for (int k = 0; k < 8; k++) begin
      req_valid_i = '1;
      req_ready_i = 1'b1;
      rsp_ready_i = '1;
      rsp_valid_i = (m_q.size() > 0);
      rand_data();
      settle_check();
`ifdef IDMA_JOB_ARB_FIXED_PRIO_EN
      exp_rr = 2'b01;
`else
      exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_grant", req_ready_o, exp_rr);
      clock_model();
    end
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      rsp_valid_i = (m_q.size() > 0);
      rand_data();
      cycle();
    end
    rsp_valid_i = 1'b0;
    chk("rr_rsp_cnt0", rsp_cnt[0], EXP_CNT0);
    chk("rr_rsp_cnt1", rsp_cnt[1], EXP_CNT1);

    // Grant lock: source 1 stalled for 3 cycles, source 0 joins in cycle 2.
    req_valid_i = 2'b10;
    req_i[1]    = 8'hA5;
    req_i[0]    = 8'h3C;
    req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) req_valid_i = 2'b11;
      settle_check();
      chk("lock_req_o", req_o, 8'hA5);
      chk("lock_ready0", req_ready_o[0], 1'b0);
      clock_model();
    end
    req_ready_i = 1'b1;
    settle_check();
    chk("lock_hs", req_ready_o, 2'b10);
    chk("lock_hs_data", req_o, 8'hA5);
    clock_model();
    req_valid_i = 2'b01;
    settle_check();
    chk("lock_next", req_ready_o, 2'b01);
    chk("lock_next_data", req_o, 8'h3C);
    clock_model();
    req_valid_i = '0;
    req_ready_i = 1'b0;

    // Response routing with backpressure: tags [1,0] outstanding.
    rsp_valid_i = 1'b1;
    rsp_ready_i = 2'b01;
    for (int k = 0; k < 2; k++) begin
      rsp_i = rsp_t'($urandom);
      settle_check();
      chk("route_valid_held", rsp_valid_o, 2'b10);
      chk("route_ready_held", rsp_ready_o, 1'b0);
      clock_model();
    end
    rsp_ready_i = 2'b11;
    settle_check();
    chk("route_pop", rsp_ready_o, 1'b1);
    clock_model();
    settle_check();
    chk("route_head0", rsp_valid_o, 2'b01);
    clock_model();
    rsp_valid_i = 1'b0;
    cycle();
    chk("route_empty", busy_o, 1'b0);

    // Full FIFO: four accepted jobs, no responses.
    req_valid_i = '1;
    req_ready_i = 1'b1;
    for (int k = 0; k < M; k++) begin
      rand_data();
      cycle();
    end
    settle_check();
    chk("full_req_valid", req_valid_o, 1'b0);
    chk("full_busy", busy_o, 1'b1);
    chk("full_req_ready", req_ready_o, '0);
    clock_model();
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    settle_check();
    chk("full_pop_cycle_no_grant", req_valid_o, 1'b0);
    chk("full_pop", rsp_ready_o, 1'b1);
    clock_model();
    rsp_valid_i = 1'b0;
    settle_check();
    chk("full_after_pop_grant", req_valid_o, 1'b1);
    clock_model();
    req_valid_i = '0;
    for (int k = 0; k < M + 1; k++) begin
      rsp_valid_i = (m_q.size() > 0);
      rsp_i       = rsp_t'($urandom);
      cycle();
    end
    rsp_valid_i = 1'b0;

    // Reset mid-flight with three jobs outstanding.
    req_valid_i = '1;
    req_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      cycle();
    end
    chk("pre_reset_busy", busy_o, 1'b1);
    req_valid_i = '0;
    req_ready_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_req_valid", req_valid_o, 1'b0);
    chk("arst_rsp_valid", rsp_valid_o, '0);
    chk("arst_rsp_ready", rsp_ready_o, 1'b0);
    chk("arst_req_ready", req_ready_o, '0);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_valid_i = 1'b1;
    rsp_ready_i = '1;
    #1;
    chk("stray_rsp_valid", rsp_valid_o, '0);
    chk("stray_rsp_ready", rsp_ready_o, 1'b0);
    rsp_valid_i = 1'b0;
    cycle();

    // Random traffic; a source keeps valid and data stable until accepted.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          req_valid_i[i] = ($urandom_range(0, 99) < 60);
          req_i[i]       = req_t'($urandom);
        end
      end
      req_ready_i = ($urandom_range(0, 99) < 60);
      rsp_valid_i = (m_q.size() > 0) && ($urandom_range(0, 99) < 60);
      rsp_ready_i = N'($urandom);
      rsp_i       = rsp_t'($urandom);
      cycle();
      for (int i = 0; i < N; i++) pend[i] = req_valid_i[i] && (i != last_push);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
